// File: rtl/prefetch_buffer.sv
// Prefetch buffer: holds prefetched lines, fetched one at a time from memory, until a demand hit consumes them.
// Build option PF_STATS_EN adds saturating issue/hit/drop counters.
module prefetch_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pf_v,
  input  logic [AW-1:0] pf_addr,
  output logic          pf_drop,
  output logic          mem_req_v,
  input  logic          mem_req_rdy,
  output logic [AW-1:0] mem_req_addr,
  input  logic          mem_resp_v,
  input  logic [DW-1:0] mem_resp_data,
  input  logic          dmd_v,
  input  logic [AW-1:0] dmd_addr,
  output logic          dmd_hit,
  output logic [DW-1:0] dmd_data
`ifdef PF_STATS_EN
  ,
  output logic [15:0]   stat_issued,
  output logic [15:0]   stat_hits,
  output logic [15:0]   stat_drops
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {E_INVALID = 2'd0, E_PENDING = 2'd1, E_INFLIGHT = 2'd2, E_READY = 2'd3} ent_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} fsm_e;

  ent_e          est_q   [DEPTH];
  ent_e          est_d   [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [AW-1:0] addr_d  [DEPTH];
  logic [DW-1:0] data_q  [DEPTH];
  logic [DW-1:0] data_d  [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d, sel_q, sel_d;
  fsm_e          fsm_q, fsm_d;
  logic          req_v_q, req_v_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic          drop_q, drop_d, hit_q, hit_d;
  logic [DW-1:0] hdata_q, hdata_d;

  logic          pend_found, dup, slot_found;
  logic [PW-1:0] pend_idx, slot_idx, idx;

  always_comb begin
    est_d      = est_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rptr_d     = rptr_q;
    sel_d      = sel_q;
    fsm_d      = fsm_q;
    req_v_d    = req_v_q;
    req_addr_d = req_addr_q;
    drop_d     = 1'b0;
    hit_d      = 1'b0;
    hdata_d    = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    dup        = 1'b0;
    slot_found = 1'b0;
    slot_idx   = '0;
    idx        = '0;

    // Demand compares against pre-edge state; a READY hit is consumed.
    if (dmd_v) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (est_q[PW'(i)] == E_READY && addr_q[PW'(i)] == dmd_addr) begin
          hit_d            = 1'b1;
          hdata_d          = data_q[PW'(i)];
          est_d[PW'(i)]    = E_INVALID;
        end
      end
    end

    case (fsm_q)
      S_IDLE: begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          idx = rptr_q + PW'(k);
          if (!pend_found && est_q[idx] == E_PENDING) begin
            pend_found = 1'b1;
            pend_idx   = idx;
          end
        end
        if (pend_found) begin
          est_d[pend_idx] = E_INFLIGHT;
          sel_d           = pend_idx;
          req_v_d         = 1'b1;
          req_addr_d      = addr_q[pend_idx];
          fsm_d           = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_rdy) begin
          req_v_d = 1'b0;
          fsm_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_v) begin
          est_d[sel_q]  = E_READY;
          data_d[sel_q] = mem_resp_data;
          fsm_d         = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    // Insert sees post-consume state; an entry filled this same edge is not yet reusable.
    if (pf_v) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (est_d[PW'(i)] != E_INVALID && addr_q[PW'(i)] == pf_addr) dup = 1'b1;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        idx = rptr_q + PW'(k);
        if (!slot_found && (est_d[idx] == E_INVALID ||
                            (est_d[idx] == E_READY && est_q[idx] == E_READY))) begin
          slot_found = 1'b1;
          slot_idx   = idx;
        end
      end
      if (!dup) begin
        if (slot_found) begin
          est_d[slot_idx]  = E_PENDING;
          addr_d[slot_idx] = pf_addr;
          rptr_d           = slot_idx + PW'(1);
        end else begin
          drop_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        est_q[PW'(i)]  <= E_INVALID;
        addr_q[PW'(i)] <= '0;
        data_q[PW'(i)] <= '0;
      end
      rptr_q     <= '0;
      sel_q      <= '0;
      fsm_q      <= S_IDLE;
      req_v_q    <= 1'b0;
      req_addr_q <= '0;
      drop_q     <= 1'b0;
      hit_q      <= 1'b0;
      hdata_q    <= '0;
    end else begin
      est_q      <= est_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rptr_q     <= rptr_d;
      sel_q      <= sel_d;
      fsm_q      <= fsm_d;
      req_v_q    <= req_v_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
      hit_q      <= hit_d;
      hdata_q    <= hdata_d;
    end
  end

  assign pf_drop      = drop_q;
  assign mem_req_v    = req_v_q;
  assign mem_req_addr = req_addr_q;
  assign dmd_hit      = hit_q;
  assign dmd_data     = hdata_q;

`ifdef PF_STATS_EN
  localparam int unsigned SW = 16;
  localparam logic [SW-1:0] SAT = '1;

  logic [SW-1:0] iss_q, hits_q, drops_q;

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_q   <= '0;
      hits_q  <= '0;
      drops_q <= '0;
    end else begin
      if (req_v_q && mem_req_rdy && iss_q != SAT) iss_q <= iss_q + SW'(1);
      if (hit_q && hits_q != SAT) hits_q <= hits_q + SW'(1);
      if (drop_q && drops_q != SAT) drops_q <= drops_q + SW'(1);
    end
  end

  assign stat_issued = iss_q;
  assign stat_hits   = hits_q;
  assign stat_drops  = drops_q;
`endif

endmodule

// File: tb/tb_prefetch_buffer.sv
// Bench for prefetch_buffer: directed scenarios plus random traffic against an entry-list model.
module tb_prefetch_buffer;
  localparam int DEPTH  = 4;
  localparam int K_FREE = 0;
  localparam int K_WAIT = 1;
  localparam int K_HAVE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pf_v, mem_req_rdy, mem_resp_v, dmd_v;
  logic [15:0] pf_addr, mem_resp_data, dmd_addr;
  logic        pf_drop, mem_req_v, dmd_hit;
  logic [15:0] mem_req_addr, dmd_data;
`ifdef PF_STATS_EN
  logic [15:0] stat_issued, stat_hits, stat_drops;
`endif

  prefetch_buffer #(.DEPTH(DEPTH), .AW(16), .DW(16)) dut (
    .clk(clk), .reset(reset), .pf_v(pf_v), .pf_addr(pf_addr), .pf_drop(pf_drop),
    .mem_req_v(mem_req_v), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
    .mem_resp_v(mem_resp_v), .mem_resp_data(mem_resp_data),
    .dmd_v(dmd_v), .dmd_addr(dmd_addr), .dmd_hit(dmd_hit), .dmd_data(dmd_data)
`ifdef PF_STATS_EN
    , .stat_issued(stat_issued), .stat_hits(stat_hits), .stat_drops(stat_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: each slot is free, waiting for data, or holding data.
  int          m_kind [DEPTH];
  logic [15:0] m_addr [DEPTH];
  logic [15:0] m_data [DEPTH];
  int          m_rptr;
  logic        exp_hit, exp_drop;
  logic [15:0] exp_data;

  bit          out_v;
  logic [15:0] out_addr;
  int          out_delay;
  int          fixed_lat = -1;
  bit          mem_hold = 0;

  function automatic logic [15:0] memdata(input logic [15:0] a);
    if (a == 16'h0100) return 16'hBEEF;
    return a ^ 16'hC3C3;
  endfunction

  function automatic int find_kind(input int kind, input logic [15:0] a);
    int r = -1;
    for (int i = 0; i < DEPTH; i++)
      if (r < 0 && m_kind[i] == kind && m_addr[i] == a) r = i;
    return r;
  endfunction

  function automatic bit any_wait();
    bit r = 0;
    for (int i = 0; i < DEPTH; i++) if (m_kind[i] == K_WAIT) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_kind[i] = K_FREE; m_addr[i] = '0; m_data[i] = '0;
    end
    m_rptr = 0; exp_hit = 0; exp_drop = 0; exp_data = '0; out_v = 0;
  endtask

  task automatic model_step();
    bit nh = 0; bit nd_drop = 0; logic [15:0] nd = '0;
    int fill = -1; int tgt = -1; bit dup = 0; int i;
    if (dmd_v) begin
      i = find_kind(K_HAVE, dmd_addr);
      if (i >= 0) begin nh = 1; nd = m_data[i]; m_kind[i] = K_FREE; end
    end
    if (mem_resp_v && out_v) fill = find_kind(K_WAIT, out_addr);
    if (pf_v) begin
      for (int j = 0; j < DEPTH; j++) if (m_kind[j] != K_FREE && m_addr[j] == pf_addr) dup = 1;
      if (!dup) begin
        for (int k = 0; k < DEPTH; k++) begin
          i = (m_rptr + k) % DEPTH;
          if (tgt < 0 && m_kind[i] != K_WAIT) tgt = i;
        end
        if (tgt >= 0) begin
          m_kind[tgt] = K_WAIT; m_addr[tgt] = pf_addr; m_rptr = (tgt + 1) % DEPTH;
        end else nd_drop = 1;
      end
    end
    if (fill >= 0) begin m_kind[fill] = K_HAVE; m_data[fill] = mem_resp_data; end
    exp_hit = nh; exp_data = nd; exp_drop = nd_drop;
  endtask

  // Advance one clock from a negedge: memory responder, model, then next negedge.
  task automatic cycle();
    bit hs, taken; logic [15:0] hs_addr;
    if (!mem_hold) begin
      if (out_v && out_delay == 0) begin mem_resp_v = 1; mem_resp_data = memdata(out_addr); end
      else mem_resp_v = 0;
    end
    hs = mem_req_v && mem_req_rdy; hs_addr = mem_req_addr;
    taken = mem_resp_v && out_v;
    model_step();
    if (out_v && out_delay > 0) out_delay--;
    if (taken) out_v = 0;
    if (hs) begin
      out_v = 1; out_addr = hs_addr;
      out_delay = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle();
    pf_v = 0; dmd_v = 0; mem_req_rdy = 1;
  endtask

  task automatic do_reset();
    reset = 1; idle(); mem_resp_v = 0; mem_resp_data = '0; mem_hold = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic run_until_have(input logic [15:0] a, output int reqs, output bit drop_seen,
                                output bit timeout);
    reqs = 0; drop_seen = 0; timeout = 1;
    for (int c = 0; c < 40; c++) begin
      if (find_kind(K_HAVE, a) >= 0) begin timeout = 0; break; end
      if (pf_drop) drop_seen = 1;
      if (mem_req_v && mem_req_rdy && mem_req_addr == a) reqs++;
      cycle();
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (!any_wait() && !out_v) break;
      cycle();
    end
    n_vec++;
    if (any_wait() || out_v) begin n_err++; $display("FAIL drain: buffer still fetching after 100 cycles"); end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (pf_drop !== 1'b0) begin n_err++; $display("FAIL reset_drop: got %b exp 0", pf_drop); end
    n_vec++; if (mem_req_v !== 1'b0) begin n_err++; $display("FAIL reset_req_v: got %b exp 0", mem_req_v); end
    n_vec++; if (dmd_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b exp 0", dmd_hit); end
    n_vec++; if (mem_req_addr !== 16'h0) begin n_err++; $display("FAIL reset_req_addr: got %h exp 0000", mem_req_addr); end
    n_vec++; if (dmd_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h exp 0000", dmd_data); end
    cycle();
    n_vec++; if (mem_req_v !== 1'b0) begin n_err++; $display("FAIL reset_idle_req: got %b exp 0", mem_req_v); end
  endtask

  task automatic test_basic();
    int reqs; bit ds, to;
    fixed_lat = 2;
    pf_v = 1; pf_addr = 16'h0100; cycle(); pf_v = 0;
    run_until_have(16'h0100, reqs, ds, to);
    n_vec++; if (to) begin n_err++; $display("FAIL basic_fill: 0100 never became ready"); end
    n_vec++; if (reqs !== 1) begin n_err++; $display("FAIL basic_reqs: got %0d exp 1", reqs); end
    dmd_v = 1; dmd_addr = 16'h0100; cycle(); dmd_v = 0;
    n_vec++; if (dmd_hit !== 1'b1) begin n_err++; $display("FAIL basic_hit: got %b exp 1", dmd_hit); end
    n_vec++; if (dmd_data !== 16'hBEEF) begin n_err++; $display("FAIL basic_data: got %h exp beef", dmd_data); end
    dmd_v = 1; dmd_addr = 16'h0100; cycle(); dmd_v = 0;
    n_vec++; if (dmd_hit !== 1'b0) begin n_err++; $display("FAIL basic_rehit: got %b exp 0", dmd_hit); end
    n_vec++; if (dmd_data !== 16'h0) begin n_err++; $display("FAIL basic_redata: got %h exp 0000", dmd_data); end
    fixed_lat = -1;
  endtask

  task automatic test_back_to_back();
    int reqs; bit ds, to; bit d0;
    pf_v = 1; pf_addr = 16'h0200; cycle();
    d0 = pf_drop;
    cycle(); pf_v = 0;
    run_until_have(16'h0200, reqs, ds, to);
    n_vec++; if (to) begin n_err++; $display("FAIL b2b_fill: 0200 never became ready"); end
    n_vec++; if (reqs !== 1) begin n_err++; $display("FAIL b2b_reqs: got %0d exp 1", reqs); end
    n_vec++; if ((d0 | ds) !== 1'b0) begin n_err++; $display("FAIL b2b_drop: got %b exp 0", d0 | ds); end
  endtask

  task automatic test_drop();
    do_reset();
    mem_req_rdy = 0;
    for (int j = 0; j < 5; j++) begin
      pf_v = 1; pf_addr = 16'h0010 + 16'(j); cycle();
      n_vec++;
      if (pf_drop !== (j == 4)) begin n_err++; $display("FAIL drop_%0d: got %b exp %b", j, pf_drop, j == 4); end
    end
    pf_v = 0;
    n_vec++; if (mem_req_v !== 1'b1) begin n_err++; $display("FAIL drop_req_v: got %b exp 1", mem_req_v); end
    n_vec++; if (mem_req_addr !== 16'h0010) begin n_err++; $display("FAIL drop_req_addr: got %h exp 0010", mem_req_addr); end
    cycle();
    n_vec++; if (pf_drop !== 1'b0) begin n_err++; $display("FAIL drop_pulse: got %b exp 0", pf_drop); end
    n_vec++; if (mem_req_addr !== 16'h0010) begin n_err++; $display("FAIL drop_hold: got %h exp 0010", mem_req_addr); end
    mem_req_rdy = 1;
    drain();
  endtask

  task automatic test_overwrite();
    int reqs; bit ds, to;
    pf_v = 1; pf_addr = 16'h0030; cycle(); pf_v = 0;
    run_until_have(16'h0030, reqs, ds, to);
    pf_v = 1; pf_addr = 16'h0031; cycle(); pf_v = 0;
    run_until_have(16'h0031, reqs, ds, to);
    n_vec++; if (to) begin n_err++; $display("FAIL ovw_fill: 0031 never became ready"); end
    dmd_v = 1; dmd_addr = 16'h0010; cycle();
    n_vec++; if (dmd_hit !== 1'b0) begin n_err++; $display("FAIL ovw_0010: got %b exp 0", dmd_hit); end
    dmd_addr = 16'h0011; cycle();
    n_vec++; if (dmd_hit !== 1'b0) begin n_err++; $display("FAIL ovw_0011: got %b exp 0", dmd_hit); end
    dmd_addr = 16'h0012; cycle();
    n_vec++; if ({dmd_hit, dmd_data} !== {1'b1, 16'hC3D1}) begin
      n_err++; $display("FAIL ovw_0012: got %b/%h exp 1/c3d1", dmd_hit, dmd_data); end
    dmd_addr = 16'h0030; cycle(); dmd_v = 0;
    n_vec++; if ({dmd_hit, dmd_data} !== {1'b1, 16'hC3F3}) begin
      n_err++; $display("FAIL ovw_0030: got %b/%h exp 1/c3f3", dmd_hit, dmd_data); end
  endtask

  task automatic test_reset_wait();
    do_reset();
    mem_hold = 1;
    pf_v = 1; pf_addr = 16'h0050; cycle(); pf_v = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_v) break;
      cycle();
    end
    n_vec++; if (!out_v) begin n_err++; $display("FAIL rstw_issue: no request for 0050"); end
    reset = 1; @(negedge clk); reset = 0;
    model_reset();
    mem_resp_v = 1; mem_resp_data = 16'h1234; cycle();
    mem_resp_v = 0; mem_hold = 0;
    n_vec++; if ({pf_drop, mem_req_v, dmd_hit} !== 3'b000) begin
      n_err++; $display("FAIL rstw_flags: got %b exp 000", {pf_drop, mem_req_v, dmd_hit}); end
    n_vec++; if ({mem_req_addr, dmd_data} !== 32'h0) begin
      n_err++; $display("FAIL rstw_buses: got %h exp 0", {mem_req_addr, dmd_data}); end
    dmd_v = 1; dmd_addr = 16'h0050; cycle(); dmd_v = 0;
    n_vec++; if (dmd_hit !== 1'b0) begin n_err++; $display("FAIL rstw_dmd: got %b exp 0", dmd_hit); end
    n_vec++; if (mem_req_v !== 1'b0) begin n_err++; $display("FAIL rstw_noreq: got %b exp 0", mem_req_v); end
  endtask

  task automatic test_random();
    int stall = 0; bit prev_v = 0; bit prev_rdy = 1; logic [15:0] prev_addr = '0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      n_vec++; if (dmd_hit !== exp_hit) begin n_err++; $display("FAIL rand_hit @%0d: got %b exp %b", c, dmd_hit, exp_hit); end
      n_vec++; if (dmd_data !== exp_data) begin n_err++; $display("FAIL rand_data @%0d: got %h exp %h", c, dmd_data, exp_data); end
      n_vec++; if (pf_drop !== exp_drop) begin n_err++; $display("FAIL rand_drop @%0d: got %b exp %b", c, pf_drop, exp_drop); end
      pf_v = ($urandom_range(0, 1) == 1); pf_addr = 16'h0040 | 16'($urandom_range(0, 5));
      dmd_v = ($urandom_range(0, 1) == 1); dmd_addr = 16'h0040 | 16'($urandom_range(0, 5));
      mem_req_rdy = ($urandom_range(0, 9) < 7);
      if (mem_req_v && prev_v && !prev_rdy) begin
        n_vec++; if (mem_req_addr !== prev_addr) begin
          n_err++; $display("FAIL rand_hold @%0d: got %h exp %h", c, mem_req_addr, prev_addr); end
      end
      if (mem_req_v && mem_req_rdy) begin
        n_vec++; if (find_kind(K_WAIT, mem_req_addr) < 0) begin
          n_err++; $display("FAIL rand_req_addr @%0d: got %h exp a waiting addr", c, mem_req_addr); end
      end
      if (any_wait() && !out_v && !mem_req_v) stall++; else stall = 0;
      if (stall > 3) begin
        n_vec++; n_err++; stall = 0;
        $display("FAIL rand_stall @%0d: got no request exp one within 3 cycles", c);
      end
      prev_v = mem_req_v; prev_rdy = mem_req_rdy; prev_addr = mem_req_addr;
      cycle();
    end
    idle();
  endtask

`ifdef PF_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int j = 0; j < 3; j++) begin pf_v = 1; pf_addr = 16'h0060 + 16'(j); cycle(); end
    pf_v = 0;
    drain();
    dmd_v = 1; dmd_addr = 16'h0060; cycle();
    dmd_addr = 16'h0061; cycle(); dmd_v = 0;
    mem_req_rdy = 0;
    for (int j = 0; j < 5; j++) begin pf_v = 1; pf_addr = 16'h0070 + 16'(j); cycle(); end
    pf_v = 0;
    repeat (2) cycle();
    n_vec++; if (stat_issued !== 16'd3) begin n_err++; $display("FAIL stat_issued: got %0d exp 3", stat_issued); end
    n_vec++; if (stat_hits !== 16'd2) begin n_err++; $display("FAIL stat_hits: got %0d exp 2", stat_hits); end
    n_vec++; if (stat_drops !== 16'd1) begin n_err++; $display("FAIL stat_drops: got %0d exp 1", stat_drops); end
    idle();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1; pf_v = 0; pf_addr = '0; dmd_v = 0; dmd_addr = '0;
    mem_req_rdy = 1; mem_resp_v = 0; mem_resp_data = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_drop();
    test_overwrite();
    test_reset_wait();
    test_random();
`ifdef PF_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
